mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_types.sv | 16 +
 rtl/mem_port_latch.sv | 58 +++++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared type definitions for the memory arbiter slice.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    IMEM_BUSY,
    DMEM_BUSY,
    RESPOND
  } arb_state_t;

  typedef enum logic {
    ARB_IMEM,
    ARB_DMEM
  } arb_port_t;

endpackage

// File: rtl/mem_port_latch.sv
// Per-port request capture. Holds one request until cleared after its response.
// The req_* outputs present the stored request, or the arriving one when nothing is
// stored, so the arbiter can grant a request in the same cycle it is presented.
module mem_port_latch #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            rmask,
  input  logic [3:0]            wmask,
  input  logic [31:0]           wdata,
  input  logic                  clear,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [3:0]            req_rmask,
  output logic [3:0]            req_wmask,
  output logic [31:0]           req_wdata
);

  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            rmask_q;
  logic [3:0]            wmask_q;
  logic [31:0]           wdata_q;
  logic                  req;

  assign req = (rmask | wmask) != 4'b0;

  // Capture a new request only when idle; further requests are ignored until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      rmask_q <= 4'b0;
      wmask_q <= 4'b0;
      wdata_q <= 32'b0;
    end else if (!pend_q && req) begin
      pend_q  <= 1'b1;
      addr_q  <= addr;
      rmask_q <= rmask;
      wmask_q <= wmask;
      wdata_q <= wdata;
    end else if (clear) begin
      pend_q  <= 1'b0;
    end
  end

  // Stored request wins; otherwise expose the one arriving this cycle.
  always_comb begin
    pending   = pend_q | req;
    req_addr  = pend_q ? addr_q  : addr;
    req_rmask = pend_q ? rmask_q : rmask;
    req_wmask = pend_q ? wmask_q : wmask;
    req_wdata = pend_q ? wdata_q : wdata;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU instruction and data ports onto one registered backing-memory port.
// Optional macro ARB_ROUND_ROBIN_EN: on a tie grant the port not granted last;
// otherwise dmem has fixed priority.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [3:0]            imem_rmask,
  output logic [31:0]           imem_rdata,
  output logic                  imem_resp,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [3:0]            dmem_rmask,
  input  logic [3:0]            dmem_wmask,
  input  logic [31:0]           dmem_wdata,
  output logic [31:0]           dmem_rdata,
  output logic                  dmem_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_rmask,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t            state_q, state_d;
  arb_port_t             grant_q, grant_d, sel;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_rmask_q, mem_rmask_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           imem_rdata_q, imem_rdata_d;
  logic [31:0]           dmem_rdata_q, dmem_rdata_d;
  logic                  i_clear, d_clear;

  logic                  i_pending, d_pending;
  logic [ADDR_WIDTH-1:0] i_addr, d_addr;
  logic [3:0]            i_rmask, i_wmask, d_rmask, d_wmask;
  logic [31:0]           i_wdata, d_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_t last_q, last_d;
`endif

  mem_port_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_imem_latch (
    .clk      (clk),
    .rst      (rst),
    .addr     (imem_addr),
    .rmask    (imem_rmask),
    .wmask    (4'b0),
    .wdata    (32'b0),
    .clear    (i_clear),
    .pending  (i_pending),
    .req_addr (i_addr),
    .req_rmask(i_rmask),
    .req_wmask(i_wmask),
    .req_wdata(i_wdata)
  );

  mem_port_latch #(.ADDR_WIDTH(ADDR_WIDTH)) u_dmem_latch (
    .clk      (clk),
    .rst      (rst),
    .addr     (dmem_addr),
    .rmask    (dmem_rmask),
    .wmask    (dmem_wmask),
    .wdata    (dmem_wdata),
    .clear    (d_clear),
    .pending  (d_pending),
    .req_addr (d_addr),
    .req_rmask(d_rmask),
    .req_wmask(d_wmask),
    .req_wdata(d_wdata)
  );

  // Port selection when both may be pending.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (i_pending && d_pending) begin
      sel = (last_q == ARB_IMEM) ? ARB_DMEM : ARB_IMEM;
    end else begin
      sel = d_pending ? ARB_DMEM : ARB_IMEM;
    end
`else
    sel = d_pending ? ARB_DMEM : ARB_IMEM;
`endif
  end

  // Next-state and datapath updates; mem_* and rdata registers hold unless loaded.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mem_addr_d   = mem_addr_q;
    mem_rmask_d  = mem_rmask_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    i_clear      = 1'b0;
    d_clear      = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d       = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_pending || d_pending) begin
          grant_d     = sel;
          mem_addr_d  = (sel == ARB_DMEM) ? d_addr  : i_addr;
          mem_rmask_d = (sel == ARB_DMEM) ? d_rmask : i_rmask;
          mem_wmask_d = (sel == ARB_DMEM) ? d_wmask : i_wmask;
          mem_wdata_d = (sel == ARB_DMEM) ? d_wdata : i_wdata;
          state_d     = (sel == ARB_DMEM) ? DMEM_BUSY : IMEM_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = sel;
`endif
        end
      end
      IMEM_BUSY, DMEM_BUSY: begin
        if (mem_resp) begin
          mem_rmask_d = 4'b0;
          mem_wmask_d = 4'b0;
          if (grant_q == ARB_IMEM) begin
            imem_rdata_d = mem_rdata;
          end else begin
            // Write-only requests return zero data.
            dmem_rdata_d = (mem_rmask_q != 4'b0) ? mem_rdata : 32'b0;
          end
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        i_clear = (grant_q == ARB_IMEM);
        d_clear = (grant_q == ARB_DMEM);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= ARB_IMEM;
      mem_addr_q   <= '0;
      mem_rmask_q  <= 4'b0;
      mem_wmask_q  <= 4'b0;
      mem_wdata_q  <= 32'b0;
      imem_rdata_q <= 32'b0;
      dmem_rdata_q <= 32'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_rmask_q  <= mem_rmask_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant flag starts at imem so dmem wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ARB_IMEM;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Response pulses decode directly from registered state.
  always_comb begin
    imem_resp  = (state_q == RESPOND) && (grant_q == ARB_IMEM);
    dmem_resp  = (state_q == RESPOND) && (grant_q == ARB_DMEM);
    imem_rdata = imem_rdata_q;
    dmem_rdata = dmem_rdata_q;
    mem_addr   = mem_addr_q;
    mem_rmask  = mem_rmask_q;
    mem_wmask  = mem_wmask_q;
    mem_wdata  = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; inputs driven 1ns after posedge, outputs checked there.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  int n_total = 0;
  int n_bad   = 0;
  int n_iresp = 0;
  int n_dresp = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata),
    .imem_resp (imem_resp),
    .dmem_addr (dmem_addr),
    .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_resp (dmem_resp),
    .mem_addr  (mem_addr),
    .mem_rmask (mem_rmask),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  // Count response pulses.
  always @(negedge clk) begin
    if (imem_resp) n_iresp++;
    if (dmem_resp) n_dresp++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cpu();
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
  endtask

  int          ib, db;
  logic        stable;
  logic [31:0] exp_seq [4];

  initial begin
    rst = 1'b1;
    imem_addr = 0; imem_rmask = 0;
    dmem_addr = 0; dmem_rmask = 0; dmem_wmask = 0; dmem_wdata = 0;
    mem_rdata = 0; mem_resp = 0;
    tick(); tick();
    chk("rst_mem_rmask", {28'b0, mem_rmask}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resps", {30'b0, imem_resp, dmem_resp}, 32'h0);
    rst = 1'b0;
    tick();

    // Single imem read with 3-cycle memory latency.
    ib = n_iresp; db = n_dresp;
    imem_rmask = 4'hF; imem_addr = 32'h6000_0000;
    tick();
    clear_cpu();
    chk("i1_mem_rmask", {28'b0, mem_rmask}, 32'hF);
    chk("i1_mem_addr", mem_addr, 32'h6000_0000);
    tick(); tick();
    mem_resp = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    mem_resp = 1'b0;
    chk("i1_resp", {31'b0, imem_resp}, 32'h1);
    chk("i1_rdata", imem_rdata, 32'h0000_0013);
    chk("i1_mask_clr", {28'b0, mem_rmask}, 32'h0);
    tick(); tick(); tick();
    chk("i1_iresp_cnt", n_iresp - ib, 32'd1);
    chk("i1_dresp_cnt", n_dresp - db, 32'd0);

    // Simultaneous imem read and dmem write, minimum latency.
    imem_rmask = 4'hF; imem_addr = 32'h100;
    dmem_wmask = 4'hF; dmem_addr = 32'h200; dmem_wdata = 32'hDEAD_BEEF;
    tick();
    clear_cpu();
    chk("w_mem_addr", mem_addr, 32'h200);
    chk("w_mem_wmask", {28'b0, mem_wmask}, 32'hF);
    chk("w_mem_rmask", {28'b0, mem_rmask}, 32'h0);
    chk("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_resp = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_resp = 1'b0;
    chk("w_dresp", {30'b0, imem_resp, dmem_resp}, 32'h1);
    chk("w_drdata", dmem_rdata, 32'h0);
    tick();
    chk("w_idle_rmask", {28'b0, mem_rmask}, 32'h0);
    tick();
    chk("r_mem_addr", mem_addr, 32'h100);
    chk("r_mem_masks", {24'b0, mem_rmask, mem_wmask}, 32'hF0);
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_resp = 1'b0;
    chk("r_iresp", {30'b0, imem_resp, dmem_resp}, 32'h2);
    chk("r_irdata", imem_rdata, 32'hCAFE_0001);
    tick();
    chk("hold_iresp", {31'b0, imem_resp}, 32'h0);
    chk("hold_irdata", imem_rdata, 32'hCAFE_0001);
    chk("hold_drdata", dmem_rdata, 32'h0);

    // dmem read+write forwarded unchanged.
    dmem_rmask = 4'hF; dmem_wmask = 4'h3; dmem_addr = 32'h400; dmem_wdata = 32'h11;
    tick();
    clear_cpu();
    chk("rw_masks", {24'b0, mem_rmask, mem_wmask}, 32'hF3);
    chk("rw_wdata", mem_wdata, 32'h11);
    mem_resp = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_resp = 1'b0;
    chk("rw_dresp", {31'b0, dmem_resp}, 32'h1);
    chk("rw_drdata", dmem_rdata, 32'h77);
    tick();

    // Stall: mem_resp low for 20 cycles.
    ib = n_iresp; db = n_dresp;
    dmem_rmask = 4'h3; dmem_addr = 32'h344; dmem_wdata = 32'h5555_AAAA;
    tick();
    clear_cpu();
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_addr !== 32'h344 || mem_rmask !== 4'h3 || mem_wmask !== 4'h0 ||
          mem_wdata !== 32'h5555_AAAA) stable = 1'b0;
      tick();
    end
    chk("stall_stable", {31'b0, stable}, 32'h1);
    chk("stall_no_resp", (n_iresp - ib) + (n_dresp - db), 32'd0);
    mem_resp = 1'b1; mem_rdata = 32'hA5A5_0F0F;
    tick();
    mem_resp = 1'b0;
    chk("stall_drdata", dmem_rdata, 32'hA5A5_0F0F);
    tick();

    // Stray mem_resp in IDLE.
    ib = n_iresp; db = n_dresp;
    mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick(); tick();
    mem_resp = 1'b0;
    chk("stray_no_resp", (n_iresp - ib) + (n_dresp - db), 32'd0);
    chk("stray_irdata", imem_rdata, 32'hCAFE_0001);
    imem_rmask = 4'hF; imem_addr = 32'h40;
    tick();
    clear_cpu();
    chk("stray_idle_grant", mem_addr, 32'h40);
    mem_resp = 1'b1; mem_rdata = 32'h4040;
    tick();
    mem_resp = 1'b0;
    chk("stray_irdata2", imem_rdata, 32'h4040);
    tick();

    // Reset during DMEM_BUSY with mem_resp high.
    dmem_rmask = 4'hF; dmem_addr = 32'h500;
    tick();
    clear_cpu();
    chk("rb_busy_addr", mem_addr, 32'h500);
    db = n_dresp;
    rst = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hBAD;
    tick();
    chk("rb_mem_addr", mem_addr, 32'h0);
    chk("rb_masks", {24'b0, mem_rmask, mem_wmask}, 32'h0);
    chk("rb_rdata", imem_rdata | dmem_rdata, 32'h0);
    chk("rb_resps", {30'b0, imem_resp, dmem_resp}, 32'h0);
    tick();
    rst = 1'b0;
    tick(); tick();
    mem_resp = 1'b0;
    tick();
    chk("rb_no_dresp", n_dresp - db, 32'd0);
    chk("rb_idle_rmask", {28'b0, mem_rmask}, 32'h0);
    imem_rmask = 4'hF; imem_addr = 32'h600;
    tick();
    clear_cpu();
    chk("rb_i_addr", mem_addr, 32'h600);
    mem_resp = 1'b1; mem_rdata = 32'h600D;
    tick();
    mem_resp = 1'b0;
    chk("rb_iresp", {31'b0, imem_resp}, 32'h1);
    chk("rb_irdata", imem_rdata, 32'h600D);
    tick();

    // Both ports requesting continuously for 4 transactions.
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq[0] = 32'h800; exp_seq[1] = 32'h700; exp_seq[2] = 32'h800; exp_seq[3] = 32'h700;
`else
    exp_seq[0] = 32'h800; exp_seq[1] = 32'h800; exp_seq[2] = 32'h800; exp_seq[3] = 32'h800;
`endif
    imem_rmask = 4'hF; imem_addr = 32'h700;
    dmem_rmask = 4'hF; dmem_addr = 32'h800;
    for (int t = 0; t < 4; t++) begin
      int w;
      w = 0;
      tick();
      while (mem_rmask == 4'h0 && w < 10) begin
        tick();
        w++;
      end
      chk($sformatf("seq_wait%0d", t), w, (w < 10) ? w : 0);
      chk($sformatf("seq_grant%0d", t), mem_addr, exp_seq[t]);
      mem_resp = 1'b1; mem_rdata = 32'h0;
      tick();
      mem_resp = 1'b0;
    end
    clear_cpu();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
